pe: RTL and testbench

- Single-neuron processing element for the SNN array: a leaky integrate-and-fire (LIF) neuron with one stored synaptic weight.
- The controller loads the weight, then pulses `accum_en` once per incoming input spike. The PE integrates the weight into its membrane potential.
- When the potential reaches threshold, the PE raises `spike` and holds it until the controller acknowledges with `spike_done`.

---
 rtl/pe.sv | 70 +++++++
 tb/tb_pe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pe.sv
// Leaky integrate-and-fire neuron with a single stored synaptic weight.
// Fires when the saturated, non-negative membrane potential reaches THRESHOLD.
module pe #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int POT_WIDTH    = 16,
    parameter int THRESHOLD    = 20,
    parameter int LEAK_SHIFT   = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [WEIGHT_WIDTH-1:0] weight_in,
    input  logic                    weight_w_en,
    input  logic                    accum_en,
    input  logic                    spike_done,
    output logic                    spike
);

    localparam logic signed [POT_WIDTH:0]   POT_MAX_EXT = {2'b00, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MAX     = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] THRESH      = POT_WIDTH'(THRESHOLD);

    logic signed [WEIGHT_WIDTH-1:0] weight;
    logic signed [POT_WIDTH-1:0]    memb_pot;

    logic signed [POT_WIDTH:0]      pot_ext;
    logic signed [POT_WIDTH:0]      leak_ext;
    logic signed [POT_WIDTH:0]      w_ext;
    logic signed [POT_WIDTH:0]      next_raw;
    logic signed [POT_WIDTH-1:0]    next_sat;
    logic                           fire;

    // One guard bit keeps the sum exact; saturation and rest clamp follow.
    always_comb begin
        pot_ext  = {memb_pot[POT_WIDTH-1], memb_pot};
        w_ext    = {{(POT_WIDTH+1-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
        leak_ext = (LEAK_SHIFT > 0) ? (pot_ext >>> LEAK_SHIFT) : '0;
        next_raw = pot_ext - leak_ext + w_ext;
        if (next_raw > POT_MAX_EXT) begin
            next_sat = POT_MAX;
        end else if (next_raw < 0) begin
            next_sat = '0;
        end else begin
            next_sat = next_raw[POT_WIDTH-1:0];
        end
        fire = (next_sat >= THRESH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            weight   <= '0;
            memb_pot <= '0;
            spike    <= 1'b0;
        end else begin
            if (weight_w_en) begin
                weight <= weight_in;
            end
            // Acknowledge wins over accumulation; spike blocks integration.
            if (spike_done) begin
                spike    <= 1'b0;
                memb_pot <= '0;
            end else if (accum_en && !spike) begin
                memb_pot <= next_sat;
                if (fire) begin
                    spike <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe.sv
// Randomized and directed bench for pe: three instances (basic, saturating, leaky)
// share stimulus and are compared every cycle against an arithmetic reference model.
module tb_pe;

    logic       clock;
    logic       reset_n;
    logic [7:0] weight_in;
    logic       weight_w_en;
    logic       accum_en;
    logic       spike_done;
    logic       spike_a, spike_s, spike_l;

    int n_checks = 0;
    int n_fail   = 0;

    pe #(.WEIGHT_WIDTH(8), .POT_WIDTH(16), .THRESHOLD(20), .LEAK_SHIFT(0)) u_a (
        .clock(clock), .reset_n(reset_n), .weight_in(weight_in), .weight_w_en(weight_w_en),
        .accum_en(accum_en), .spike_done(spike_done), .spike(spike_a));
    pe #(.WEIGHT_WIDTH(8), .POT_WIDTH(16), .THRESHOLD(32767), .LEAK_SHIFT(0)) u_s (
        .clock(clock), .reset_n(reset_n), .weight_in(weight_in), .weight_w_en(weight_w_en),
        .accum_en(accum_en), .spike_done(spike_done), .spike(spike_s));
    pe #(.WEIGHT_WIDTH(8), .POT_WIDTH(16), .THRESHOLD(100), .LEAK_SHIFT(2)) u_l (
        .clock(clock), .reset_n(reset_n), .weight_in(weight_in), .weight_w_en(weight_w_en),
        .accum_en(accum_en), .spike_done(spike_done), .spike(spike_l));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic signed [15:0] d_pot [3];
    logic signed [7:0]  d_w   [3];
    logic               d_spk [3];
    assign d_pot[0] = u_a.memb_pot;
    assign d_pot[1] = u_s.memb_pot;
    assign d_pot[2] = u_l.memb_pot;
    assign d_w[0]   = u_a.weight;
    assign d_w[1]   = u_s.weight;
    assign d_w[2]   = u_l.weight;
    assign d_spk[0] = spike_a;
    assign d_spk[1] = spike_s;
    assign d_spk[2] = spike_l;

    // Reference model: plain integer arithmetic per instance.
    int m_th [3] = '{20, 32767, 100};
    int m_ls [3] = '{0, 0, 2};
    int m_pot[3];
    int m_w  [3];
    bit m_spk[3];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_pot[i] = 0;
                m_w[i]   = 0;
                m_spk[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int n;
                if (spike_done) begin
                    m_pot[i] = 0;
                    m_spk[i] = 1'b0;
                end else if (accum_en && !m_spk[i]) begin
                    n = m_pot[i] + m_w[i];
                    if (m_ls[i] > 0) n = n - m_pot[i] / (1 << m_ls[i]);
                    if (n > 32767) n = 32767;
                    if (n < 0) n = 0;
                    m_pot[i] = n;
                    if (n >= m_th[i]) m_spk[i] = 1'b1;
                end
                if (weight_w_en) m_w[i] = int'($signed(weight_in));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pot[%0d]", i), int'(d_pot[i]), m_pot[i]);
            check($sformatf("weight[%0d]", i), int'(d_w[i]), m_w[i]);
            check($sformatf("spike[%0d]", i), int'(d_spk[i]), int'(m_spk[i]));
        end
    end

    task automatic step(input logic wen, input logic [7:0] win, input logic acc, input logic done);
        @(negedge clock);
        weight_w_en = wen;
        weight_in   = win;
        accum_en    = acc;
        spike_done  = done;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        weight_in   = '0;
        weight_w_en = 1'b0;
        accum_en    = 1'b0;
        spike_done  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pot", int'(u_a.memb_pot), 0);
        check("rst_spike", int'(spike_a), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic fire and refractory hold
        step(1'b1, 8'd10, 1'b0, 1'b0);
        check("basic_weight", int'(u_a.weight), 10);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("basic_pot1", int'(u_a.memb_pot), 10);
        check("basic_nospike", int'(spike_a), 0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("basic_pot2", int'(u_a.memb_pot), 20);
        check("basic_spike", int'(spike_a), 1);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("refr_pot", int'(u_a.memb_pot), 20);
        check("refr_spike", int'(spike_a), 1);

        // Acknowledge drops the concurrent accumulation
        step(1'b0, 8'd0, 1'b1, 1'b1);
        check("ack_spike", int'(spike_a), 0);
        check("ack_pot", int'(u_a.memb_pot), 0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("ack_reaccum", int'(u_a.memb_pot), 10);

        // Inhibition clamps at rest
        step(1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b1, 8'd5, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("inh_pot10", int'(u_a.memb_pot), 10);
        step(1'b1, 8'hF8, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("inh_pot2", int'(u_a.memb_pot), 2);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("inh_clamp", int'(u_a.memb_pot), 0);
        check("inh_nospike", int'(spike_a), 0);

        // Leak sequence on the LEAK_SHIFT=2 instance
        step(1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b1, 8'd8, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("leak_8", int'(u_l.memb_pot), 8);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("leak_14", int'(u_l.memb_pot), 14);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("leak_19", int'(u_l.memb_pot), 19);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("leak_23", int'(u_l.memb_pot), 23);
        check("leak_nospike", int'(spike_l), 0);

        // Saturation on the THRESHOLD=32767 instance
        step(1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b1, 8'd127, 1'b0, 1'b0);
        repeat (300) step(1'b0, 8'd0, 1'b1, 1'b0);
        check("sat_pot", int'(u_s.memb_pot), 32767);
        check("sat_spike", int'(spike_s), 1);

        // Asynchronous reset between edges
        step(1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b1, 8'd10, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("arst_pre", int'(u_a.memb_pot), 10);
        accum_en = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_pot", int'(u_a.memb_pot), 0);
        check("arst_weight", int'(u_a.weight), 0);
        check("arst_spike", int'(spike_a), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            if ($urandom_range(0, 3) != 0) w = 8'($urandom_range(0, 127));
            step(($urandom_range(0, 9) < 2), w, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
            end
        end

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
